// File: rtl/tlc_pkg.sv
// Shared types and default constants for the traffic light controller front end.
package tlc_pkg;

    // Request state machine encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        REQ   = 2'b01,
        SERVE = 2'b10
    } req_state_t;

    // Default filter length and stuck-sensor threshold.
    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int STUCK_CYCLES_DEF    = 1024;

endpackage

// File: rtl/car_request_conditioner_if.sv
// Sensor/lamp inputs and conditioned request outputs of the car request conditioner.
interface car_request_conditioner_if #(
    parameter int CNT_W = 8
);
    logic             sensor_raw;
    logic             green;
    logic             car;
    logic             pending;
    logic             fault;
    logic [CNT_W-1:0] arrivals;

    // The side that drives the loop sensor and lamp, and watches the request.
    modport master (
        output sensor_raw,
        output green,
        input  car,
        input  pending,
        input  fault,
        input  arrivals
    );

    // The conditioner itself.
    modport slave (
        input  sensor_raw,
        input  green,
        output car,
        output pending,
        output fault,
        output arrivals
    );
endinterface

// File: rtl/sync_debounce.sv
// Two-flop synchronizer, debounce filter and rising-edge arrival pulse for the loop sensor.
module sync_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic i_sensor_raw,
    output logic o_filtered,
    output logic o_arrival
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_filtered;
    logic          r_filteredD;
    logic [CW-1:0] r_cnt;

    // Bring the asynchronous sensor into the clock domain.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_sensor_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Change the filtered level only after enough consecutive disagreeing samples; any agreement restarts the count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_filtered <= 1'b0;
            r_cnt      <= '0;
        end else if (r_sync2 == r_filtered) begin
            r_cnt <= '0;
        end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            r_filtered <= r_sync2;
            r_cnt      <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Delayed copy of the filtered level for edge detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_filteredD <= 1'b0;
        end else begin
            r_filteredD <= r_filtered;
        end
    end

    assign o_filtered = r_filtered;
    assign o_arrival  = r_filtered & ~r_filteredD;

endmodule

// File: rtl/car_request_conditioner.sv
// Turns the raw vehicle-loop sensor into a latched car request with queuing, stuck detection and arrival counting.
module car_request_conditioner
    import tlc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int STUCK_CYCLES    = STUCK_CYCLES_DEF,
    parameter int CNT_W           = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    car_request_conditioner_if.slave  bus
);

    localparam int SW = $clog2(STUCK_CYCLES + 1);

    logic             w_filtered;
    logic             w_arrival;
    req_state_t       r_state;
    logic             r_pending;
    logic [SW-1:0]    r_stuckCnt;
    logic             r_fault;
    logic [CNT_W-1:0] r_arrivals;

    sync_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock       (clock),
        .reset       (reset),
        .i_sensor_raw(bus.sensor_raw),
        .o_filtered  (w_filtered),
        .o_arrival   (w_arrival)
    );

    // Hold each arrival until green is shown, queueing one re-request if a car arrives while being served.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_pending <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_arrival) begin
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (bus.green) begin
                        r_state   <= SERVE;
                        r_pending <= w_arrival;
                    end
                end
                SERVE: begin
                    if (!bus.green) begin
                        r_state   <= (r_pending | w_arrival) ? REQ : IDLE;
                        r_pending <= 1'b0;
                    end else if (w_arrival) begin
                        r_pending <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_pending <= 1'b0;
                end
            endcase
        end
    end

    // Count continuous filtered-high cycles and latch a sticky fault when the threshold is reached.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stuckCnt <= '0;
            r_fault    <= 1'b0;
        end else if (!w_filtered) begin
            r_stuckCnt <= '0;
        end else if (r_stuckCnt != SW'(STUCK_CYCLES)) begin
            r_stuckCnt <= r_stuckCnt + 1'b1;
            if (r_stuckCnt == SW'(STUCK_CYCLES - 1)) begin
                r_fault <= 1'b1;
            end
        end
    end

    // Saturating diagnostic count of debounced arrivals.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_arrivals <= '0;
        end else if (w_arrival && (r_arrivals != {CNT_W{1'b1}})) begin
            r_arrivals <= r_arrivals + 1'b1;
        end
    end

    assign bus.car      = (r_state == REQ) | r_fault;
    assign bus.pending  = r_pending;
    assign bus.fault    = r_fault;
    assign bus.arrivals = r_arrivals;

endmodule

// File: doc/car_request_conditioner.md
# car_request_conditioner

Front-end stage for the traffic light controller. It turns the raw, asynchronous vehicle-loop sensor into the clean, latched `car` request the controller samples in its red state. The block synchronizes and debounces the sensor, holds each arrival until the controller shows green, detects a stuck-on sensor, and counts arrivals for diagnostics.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized samples required to change the filtered level (≥1).
- `STUCK_CYCLES`, default 1024: continuous filtered-high cycles that declare a sensor fault.
- `CNT_W`, default 8: width of the arrival counter.

Ports. Reset `reset`, asynchronous, active-low; clock `clock`.
- `clock`  in  1  system clock
- `reset`  in  1  asynchronous active-low reset
- `sensor_raw`  in  1  loop detector, asynchronous to `clock`, may bounce
- `green`  in  1  green lamp from the controller, synchronous to `clock`
- `car`  out  1  latched request to the controller
- `pending`  out  1  an arrival occurred while being served; re-request queued
- `fault`  out  1  sticky stuck-sensor flag
- `arrivals`  out  CNT_W  saturating count of debounced arrivals

## Operation
- Synchronizer: 2 flops on `sensor_raw`, reset 0; output `sync2`.
- Debounce, with `filtered` reset to 0 and `cnt` of width $clog2(DEBOUNCE_CYCLES+1):
  - If `sync2 == filtered`, `cnt <= 0`.
  - Otherwise, if `cnt == DEBOUNCE_CYCLES-1`, then `filtered <= sync2` and `cnt <= 0`; else `cnt <= cnt+1`.
  - Any glitch shorter than DEBOUNCE_CYCLES restarts the count.
- `arrival` is a one-cycle pulse when `filtered` rises, derived from the registered `filtered_d` (reset 0).
- Request FSM with states IDLE, REQ, SERVE; reset to IDLE:
  - IDLE: on `arrival`, go to REQ.
  - REQ: on `green`, go to SERVE. Arrivals in REQ merge into the existing request and do not set `pending`.
  - SERVE: an `arrival` sets `pending`. On `green==0`, go to REQ if `pending` (or an `arrival` in the same cycle), else IDLE. `pending` clears on leaving SERVE.
  - `arrival` and a `green` rise in the same REQ cycle: go to SERVE and set `pending`.
- Outputs are Moore. `car = (state==REQ) | fault`.
- Stuck detector:
  - A counter increments while `filtered==1` and clears when `filtered==0`.
  - Reaching STUCK_CYCLES sets `fault`. `fault` stays set until reset.
  - The counter saturates and does not wrap.
  - While `fault` is set, `car` is forced to 1 so the intersection keeps cycling (fail-safe).
- `arrivals` increments on each `arrival` and saturates at 2^CNT_W−1.

## Timing
- Reset values: `car`=0, `pending`=0, `fault`=0, `arrivals`=0. All internal flops are 0 and the FSM is in IDLE.
- Reset is asynchronous assert, synchronous deassert by use. Reset mid-request drops `car` immediately and discards `pending` and counts.
- Latency: `sensor_raw` stable high before edge 0 reaches `sync2` after edge 2 and `filtered` after edge 2+DEBOUNCE_CYCLES. `car` rises after edge 3+DEBOUNCE_CYCLES, which is 7 edges at the default.
- Release: `filtered` falls DEBOUNCE_CYCLES+2 edges after `sensor_raw` falls; this does not affect `car`.
- `car` falls the cycle after `green` is sampled high.
- Handshake: `car` holds until `green`. The controller's one-cycle green is sufficient.

## Structure
- Shared package `tlc_pkg`: `req_state_t` enum (IDLE=2'b00, REQ=2'b01, SERVE=2'b10), plus default constants `DEBOUNCE_CYCLES_DEF` and `STUCK_CYCLES_DEF`.
- Sub-module `sync_debounce` (params DEBOUNCE_CYCLES): holds the synchronizer, the debounce counter, `filtered` and `arrival`. The top level contains the FSM, the stuck detector and the arrival counter.

## Test plan
- Reset, then `sensor_raw`=1 held: `car` rises exactly 7 edges later. Then pulse `green` for 1 cycle: `car`=0 next cycle, state IDLE, `arrivals`=1.
- Bounce: `sensor_raw` toggling with high runs of 3 cycles for 40 cycles: `filtered` never rises, `car`=0, `arrivals`=0. A 4-cycle stable high then produces `car`.
- Queued re-request: a second clean arrival while `green`=1 for 3 cycles sets `pending`=1. When `green` falls, `car`=1 next cycle and `pending`=0.
- Stuck sensor with STUCK_CYCLES=16: `sensor_raw` held high. `fault` and `car` are 1 from the cycle the count reaches 16 and stay 1 through `green` pulses until reset.
- Saturation with CNT_W=2: 5 separate arrivals give `arrivals`=3.
- Reset asserted while in REQ: `car`, `pending`, `fault` and `arrivals` all go 0 asynchronously. After release, the sequence restarts from IDLE.
